// File: rtl/usbkbd_decoder.sv
// usbkbd_decoder: parses framed HID boot-keyboard reports and queues newly pressed keys (ASCII or raw) in a FIFO.
module usbkbd_decoder #(
  parameter int                     MAGIC_LEN  = 3,
  parameter logic [MAGIC_LEN*8-1:0] MAGIC      = "key",
  parameter int                     NKEYS      = 6,
  parameter int                     FIFO_DEPTH = 8,
  parameter bit                     TRANSLATE  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_byte,
  input  logic                          i_byte_valid,
  output logic                          o_byte_ready,
  output logic                          o_key_valid,
  output logic [7:0]                    o_key,
  input  logic                          i_key_ready,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);
  localparam int IW = MAGIC_LEN > 1 ? $clog2(MAGIC_LEN) : 1;
  localparam int SW = NKEYS > 1 ? $clog2(NKEYS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {LOOK, MASK, RES, CODE, EMIT} state_t;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx;
  logic [SW-1:0]   r_slot;
  logic            r_shift, r_ctrl;
  logic [7:0]      r_cur  [NKEYS];
  logic [7:0]      r_prev [NKEYS];
  logic [7:0]      r_mem  [FIFO_DEPTH];
  logic [AW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            w_accept, w_match, w_last_idx, w_last_slot, w_new, w_roll, w_mapped;
  logic            w_push, w_pop, w_full, w_wr;
  logic [7:0]      w_mag, w_code, w_key;
  assign w_accept    = i_byte_valid && o_byte_ready;
  assign w_mag       = MAGIC[8*(MAGIC_LEN-1-int'(r_idx)) +: 8];
  assign w_match     = i_byte == w_mag;
  assign w_last_idx  = r_idx == IW'(MAGIC_LEN-1);
  assign w_last_slot = r_slot == SW'(NKEYS-1);
  assign w_code      = r_cur[r_slot];
  // A slot counts as a new press only if its code appears nowhere in the previous report.
  always_comb begin
    w_new  = w_code != 8'h00;
    w_roll = 1'b1;
    for (int k = 0; k < NKEYS; k++) begin
      if (r_prev[k] == w_code) w_new = 1'b0;
      if (r_cur[k] != 8'h01) w_roll = 1'b0;
    end
  end
  always_comb begin
    w_mapped = 1'b1;
    w_key    = w_code;
    if (TRANSLATE) begin
      w_mapped = w_code >= 8'h04 && w_code <= 8'h2C;
      w_key    = w_code <= 8'h1D ? (r_ctrl ? w_code - 8'h03 : r_shift ? w_code + 8'h3D : w_code + 8'h5D) :
                 w_code <= 8'h26 ? w_code + 8'h13 :
                 w_code == 8'h27 ? 8'h30 :
                 w_code == 8'h28 ? 8'h0D :
                 w_code == 8'h29 ? 8'h1B :
                 w_code == 8'h2A ? 8'h08 :
                 w_code == 8'h2B ? 8'h09 : 8'h20;
    end
  end
  assign w_push = r_state == EMIT && !w_roll && w_new && w_mapped;
  assign w_pop  = r_count != '0 && i_key_ready;
  assign w_full = r_count == CW'(FIFO_DEPTH);
  assign w_wr   = w_push && (!w_full || w_pop);
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOOK:    w_next = w_accept && w_match && w_last_idx ? MASK : LOOK;
      MASK:    w_next = w_accept ? RES : MASK;
      RES:     w_next = !w_accept ? RES : i_byte == 8'h00 ? CODE : LOOK;
      CODE:    w_next = w_accept && w_last_slot ? EMIT : CODE;
      default: w_next = w_last_slot ? LOOK : EMIT;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= LOOK;
      r_idx      <= '0;
      r_slot     <= '0;
      r_shift    <= 1'b0;
      r_ctrl     <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int k = 0; k < NKEYS; k++) begin
        r_cur[k]  <= 8'h00;
        r_prev[k] <= 8'h00;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_wr) begin
        r_mem[r_wr] <= w_key;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_push && !w_wr) r_overflow <= 1'b1;
      case (r_state)
        LOOK: if (w_accept)
          r_idx <= w_match ? (w_last_idx ? '0 : r_idx + 1'b1) :
                   i_byte == MAGIC[MAGIC_LEN*8-1 -: 8] ? IW'(1) : '0;
        MASK: if (w_accept) begin
          r_shift <= i_byte[1] | i_byte[5];
          r_ctrl  <= i_byte[0] | i_byte[4];
        end
        RES: if (w_accept) r_slot <= '0;
        CODE: if (w_accept) begin
          r_cur[r_slot] <= i_byte;
          r_slot        <= w_last_slot ? '0 : r_slot + 1'b1;
        end
        default: begin
          r_slot <= w_last_slot ? '0 : r_slot + 1'b1;
          if (w_last_slot && !w_roll)
            for (int k = 0; k < NKEYS; k++) r_prev[k] <= r_cur[k];
        end
      endcase
    end
  end
  assign o_byte_ready = r_state != EMIT;
  assign o_key_valid  = r_count != '0;
  assign o_key        = r_mem[r_rd];
  assign o_overflow   = r_overflow;
  assign o_fifo_count = r_count;
endmodule

// File: tb/tb_usbkbd_decoder.sv
// tb_usbkbd_decoder: directed reports against hand-computed key sequences.
module tb_usbkbd_decoder;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_byte = 8'h00;
  logic       i_byte_valid = 1'b0;
  logic       i_key_ready = 1'b1;
  logic       o_byte_ready, o_key_valid, o_overflow;
  logic [7:0] o_key;
  logic [3:0] o_fifo_count;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         lo;
  logic [7:0] got [$];
  logic [63:0] exp8;
  usbkbd_decoder dut (
    .i_clk(clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .o_key_valid(o_key_valid), .o_key(o_key),
    .i_key_ready(i_key_ready), .o_overflow(o_overflow), .o_fifo_count(o_fifo_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!i_rst && o_key_valid && i_key_ready) got.push_back(o_key);
  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    i_byte = b;
    i_byte_valid = 1'b1;
    @(negedge clk);
    while (!o_byte_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("byte_ready_timeout", 1, 0);
    @(posedge clk);
    #1 i_byte_valid = 1'b0;
  endtask
  task automatic report(input logic [7:0] m, input logic [7:0] r, input logic [47:0] c);
    send("k"); send("e"); send("y"); send(m); send(r);
    for (int i = 0; i < 6; i++) send(c[47-8*i -: 8]);
  endtask
  task automatic settle(output int low);
    low = 0;
    @(negedge clk);
    while (!o_byte_ready && low < 20) begin
      low++;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic expect_keys(input string tag, input int n, input logic [63:0] e);
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      check(tag, i < got.size() ? {24'h0, got[i]} : 32'hxxxxxxxx, {24'h0, e[8*i +: 8]});
    got.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_key_valid", o_key_valid, 0);
    check("rst_key", o_key, 8'h00);
    check("rst_byte_ready", o_byte_ready, 1);
    check("rst_overflow", o_overflow, 0);
    check("rst_count", o_fifo_count, 0);
    report(8'h00, 8'h00, 48'h04_00_00_00_00_00); settle(lo);
    check("ready_low_cycles", lo, 6);
    expect_keys("first_a", 1, 64'h61);
    report(8'h00, 8'h00, 48'h04_00_00_00_00_00); settle(lo);
    expect_keys("held_a", 0, 64'h0);
    report(8'h00, 8'h00, 48'h04_05_00_00_00_00); settle(lo);
    expect_keys("new_b", 1, 64'h62);
    report(8'h02, 8'h00, 48'h04_05_1E_00_00_00); settle(lo);
    expect_keys("shift_digit", 1, 64'h31);
    report(8'h00, 8'h00, 48'h0); settle(lo);
    expect_keys("release", 0, 64'h0);
    report(8'h01, 8'h00, 48'h06_00_00_00_00_00); settle(lo);
    expect_keys("ctrl_c", 1, 64'h03);
    report(8'h20, 8'h00, 48'h1D_00_00_00_00_00); settle(lo);
    expect_keys("rshift_z", 1, 64'h5A);
    send("k"); send("k"); send("e"); send("y"); send(8'h00); send(8'h00);
    send(8'h2C); for (int i = 0; i < 5; i++) send(8'h00);
    settle(lo);
    expect_keys("resync_space", 1, 64'h20);
    report(8'h00, 8'h05, 48'h04_00_00_00_00_00); settle(lo);
    expect_keys("res_abort", 0, 64'h0);
    report(8'h00, 8'h00, 48'h2C_00_00_00_00_00); settle(lo);
    expect_keys("prev_kept", 0, 64'h0);
    report(8'h00, 8'h00, 48'h0); settle(lo);
    i_key_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      report(8'h00, 8'h00, {8'h04 + 8'(i), 40'h0}); settle(lo);
      report(8'h00, 8'h00, 48'h0); settle(lo);
    end
    check("full_count", o_fifo_count, 8);
    check("overflow_set", o_overflow, 1);
    check("full_head", o_key, 8'h61);
    i_key_ready = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 8; i++) exp8[8*i +: 8] = 8'h61 + 8'(i);
    expect_keys("drain", 8, exp8);
    check("drain_empty", o_key_valid, 0);
    report(8'h00, 8'h00, 48'h04_00_00_00_00_00); settle(lo);
    expect_keys("pre_roll", 1, 64'h61);
    report(8'h00, 8'h00, 48'h01_01_01_01_01_01); settle(lo);
    check("roll_ready_low", lo, 6);
    expect_keys("rollover", 0, 64'h0);
    report(8'h00, 8'h00, 48'h04_00_00_00_00_00); settle(lo);
    expect_keys("post_roll", 0, 64'h0);
    i_key_ready = 1'b0;
    report(8'h00, 8'h00, 48'h05_06_07_00_00_00);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("mid_emit_count", o_fifo_count, 2);
    i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_emit_count", o_fifo_count, 0);
    check("rst_emit_valid", o_key_valid, 0);
    check("rst_emit_ready", o_byte_ready, 1);
    check("rst_emit_overflow", o_overflow, 0);
    got.delete();
    i_key_ready = 1'b1;
    report(8'h00, 8'h00, 48'h04_00_00_00_00_00); settle(lo);
    check("after_rst_ready_low", lo, 6);
    expect_keys("after_rst", 1, 64'h61);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/usbkbd_decoder.md
Name: usbkbd_decoder

Overview:
Parametrised successor to the single-key USB byte-to-UART translator. Parses framed HID boot-keyboard reports from the USB byte stream: magic, modifier mask, reserved byte, then NKEYS scan-code slots. Only newly pressed keys are emitted, compared against the previous report. Each key is optionally translated to ASCII using shift/ctrl, and results are buffered in a FIFO feeding the UART transmit side through a valid/ready handshake.

Parameters:
MAGIC_LEN, 3, number of bytes in the frame magic (1..8)
MAGIC, "key", MAGIC_LEN*8-bit magic, first byte in the MSBs
NKEYS, 6, scan-code slots per report (1..8)
FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2)
TRANSLATE, 1, 1 = ASCII translation, 0 = raw scan codes passed through

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_byte  in  8  USB stream byte
i_byte_valid  in  1  i_byte valid
o_byte_ready  out  1  block accepts i_byte this cycle
o_key_valid  out  1  FIFO head valid
o_key  out  8  FIFO head (ASCII or scan code)
i_key_ready  in  1  consumer accepts o_key
o_overflow  out  1  sticky: key dropped because FIFO full
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (i_rst high at posedge): state LOOK, magic index 0, cur[] and prev[] all 0x00, FIFO empty, o_key_valid 0, o_key 0x00, o_byte_ready 1, o_overflow 0, o_fifo_count 0. Reset mid-frame or mid-EMIT discards everything.
- A byte is accepted only when i_byte_valid && o_byte_ready. No state advances on unaccepted cycles.
- LOOK: the accepted byte is compared with MAGIC byte idx.
  - Match: idx+1. On the last match, go to MASK with idx=0.
  - Mismatch but equal to the first magic byte: idx=1.
  - Otherwise: idx=0.
- MASK: latch mask, go to RES.
- RES: byte 0x00 goes to CODE with slot=0. A nonzero byte aborts to LOOK; prev[] is unchanged.
- CODE: store the byte into cur[slot], slot+1. After slot NKEYS-1 go to EMIT with j=0.
- EMIT: o_byte_ready=0. One slot is evaluated per cycle, j=0..NKEYS-1, in slot order.
  - A slot is a new press if cur[j]!=0x00 and cur[j] is in no prev[] entry.
  - New press with a mapped code: push it to the FIFO. Unmapped codes are skipped when TRANSLATE=1.
  - After j=NKEYS-1: prev[]<=cur[], state LOOK, o_byte_ready=1 next cycle.
- Rollover error: all cur[] slots equal 0x01. Emit nothing, do not update prev[]; EMIT still spends NKEYS cycles.
- Timing: if the last code byte is accepted at edge T, slot j is pushed at edge T+1+j. o_byte_ready is low for cycles T+1..T+NKEYS.
- Translation (TRANSLATE=1). shift = mask[1]|mask[5], ctrl = mask[0]|mask[4].
  - 0x04..0x1D: ctrl gives 0x01..0x1A; else shift gives 'A'..'Z'; else 'a'..'z'.
  - 0x1E..0x26 gives '1'..'9'; 0x27 gives '0'. Shift is ignored.
  - 0x28 gives 0x0D, 0x29 gives 0x1B, 0x2A gives 0x08, 0x2B gives 0x09, 0x2C gives 0x20.
  - All other codes are unmapped.
- FIFO: o_key_valid = count!=0, and o_key = head, shown combinationally from storage. A pop occurs when o_key_valid && i_key_ready.
  - Push when full without a pop in the same cycle: the key is dropped and o_overflow is set (cleared only by reset).
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Key release (slot goes 0x00 or changes): nothing is emitted, only prev[] is updated.

Test Plan:
- Defaults, stream "k","e","y",00,00,04,00,00,00,00,00 with i_key_ready=1. Expect one key 0x61 ('a'). o_byte_ready low for exactly 6 cycles after the last byte.
- Same report repeated, then a report with slots 04,05. Expect only 0x62 ('b'). Then mask 0x02 with slots 04,05,1E. Expect only '1' (0x31), since 04 and 05 are still held.
- Mask 0x01 with slot 06, after a release report. Expect 0x03. Mask 0x20 with slot 1D. Expect 'Z' (0x5A).
- Stream "kkey",00,00,2C,... Expect magic re-sync and 0x20 emitted. Stream "key",00,05,04,... (reserved byte nonzero). Expect no key and prev[] unchanged.
- i_key_ready=0; send 10 distinct single-press reports alternating with release reports. Expect o_fifo_count=8 and o_overflow=1. Then drain: the first 8 keys appear in order.
- Report of all 0x01. Expect no output and the next identical-to-old report emits nothing. Assert i_rst during EMIT. Expect FIFO empty, o_byte_ready=1, and a following valid report emits normally.
